// File: rtl/mul_issue_sched_pkg.sv
// mul_issue_sched_pkg: shared sizes and types for the multiply issue scheduler
package mul_issue_sched_pkg;
  localparam int MUL_STAGES = 5;
  localparam int ALU_LAT = 3;
  localparam int CNT_W = 3;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/mul_sched_track.sv
// mul_sched_track: in-flight multiply valid/dst/wr shift register with raw/waw match
module mul_sched_track import mul_issue_sched_pkg::*; #(
  parameter int N = MUL_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         push_wr,
  input  logic         chk_wr,
  input  reg_idx_t     dst,
  input  reg_idx_t     src1,
  input  reg_idx_t     src2,
  output logic         raw,
  output logic         waw,
  output logic [N-1:0] sv,
  output logic         wb_valid,
  output reg_idx_t     wb_dst
);
  logic [N-1:0] wr;
  reg_idx_t sd [N];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv <= '0;
      wr <= '0;
      for (int k = 0; k < N; k++) sd[k] <= '0;
    end else begin
      sv <= flush ? '0 : {sv[N-2:0], push};
      wr <= {wr[N-2:0], push_wr};
      sd[0] <= dst;
      for (int k = 1; k < N; k++) sd[k] <= sd[k-1];
    end
  end
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 0; k < N; k++) begin
      raw = raw | (sv[k] & (((src1 != '0) & (src1 == sd[k])) | ((src2 != '0) & (src2 == sd[k]))));
      waw = waw | (sv[k] & chk_wr & (dst != '0) & (dst == sd[k]));
    end
  end
  assign wb_valid = sv[N-1] & wr[N-1];
  assign wb_dst = sd[N-1];
endmodule

// File: rtl/mul_issue_sched.sv
// mul_issue_sched: multiply pipeline issue scheduler and hazard controller
module mul_issue_sched import mul_issue_sched_pkg::*; #(
  parameter int MUL_STAGES = mul_issue_sched_pkg::MUL_STAGES,
  parameter int ALU_LAT = mul_issue_sched_pkg::ALU_LAT,
  parameter int CNT_W = mul_issue_sched_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_is_mul,
  input  logic                  issue_wr,
  input  reg_idx_t              issue_dst,
  input  reg_idx_t              issue_src1,
  input  reg_idx_t              issue_src2,
  input  logic                  flush,
  output logic                  issue_stall,
  output logic                  issue_fire,
  output logic [MUL_STAGES-1:0] stage_valid,
  output logic                  mul_wb_valid,
  output reg_idx_t              mul_wb_dst,
  output logic [CNT_W-1:0]      mul_inflight
);
  logic raw, waw, str, push;
  logic [MUL_STAGES:ALU_LAT+1] rv;
  assign str = issue_wr & ~issue_is_mul & rv[ALU_LAT+1];
  assign issue_stall = issue_valid & (raw | waw | str);
  assign issue_fire = issue_valid & ~issue_stall & ~flush;
  assign push = issue_fire & issue_is_mul;
  mul_sched_track #(.N(MUL_STAGES)) u_track (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(push),
    .push_wr(issue_wr),
    .chk_wr(issue_wr),
    .dst(issue_dst),
    .src1(issue_src1),
    .src2(issue_src2),
    .raw(raw),
    .waw(waw),
    .sv(stage_valid),
    .wb_valid(mul_wb_valid),
    .wb_dst(mul_wb_dst)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv <= '0;
      mul_inflight <= '0;
    end else if (flush) begin
      rv <= '0;
      mul_inflight <= '0;
    end else begin
      rv <= rv >> 1;
      rv[MUL_STAGES] <= push & issue_wr;
      mul_inflight <= mul_inflight + CNT_W'(push) - CNT_W'(stage_valid[MUL_STAGES-1]);
    end
  end
endmodule

// File: tb/tb_mul_issue_sched.sv
// tb_mul_issue_sched: directed and random checks of mul_issue_sched against a cycle-time model
module tb_mul_issue_sched;
  import mul_issue_sched_pkg::*;
  localparam int N = MUL_STAGES;
  localparam int L = ALU_LAT;
  logic clk = 1'b0;
  logic reset, issue_valid, issue_is_mul, issue_wr, flush;
  logic [4:0] issue_dst, issue_src1, issue_src2;
  logic issue_stall, issue_fire, mul_wb_valid;
  logic [N-1:0] stage_valid;
  logic [4:0] mul_wb_dst;
  logic [CNT_W-1:0] mul_inflight;
  int tests = 0;
  int fails = 0;
  int now = 0;
  int m_t[$];
  logic [4:0] m_d[$];
  bit m_w[$];
  bit resv [0:4095];
  always #5 clk = ~clk;
  mul_issue_sched dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_is_mul(issue_is_mul),
    .issue_wr(issue_wr),
    .issue_dst(issue_dst),
    .issue_src1(issue_src1),
    .issue_src2(issue_src2),
    .flush(flush),
    .issue_stall(issue_stall),
    .issue_fire(issue_fire),
    .stage_valid(stage_valid),
    .mul_wb_valid(mul_wb_valid),
    .mul_wb_dst(mul_wb_dst),
    .mul_inflight(mul_inflight)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask
  task automatic clear_model();
    m_t.delete();
    m_d.delete();
    m_w.delete();
    for (int j = now; j < now + N + 2; j++) resv[j] = 1'b0;
  endtask
  task automatic step(input bit v, input bit m, input bit w, input bit [4:0] d,
                      input bit [4:0] s1, input bit [4:0] s2, input bit fl, input bit rs,
                      output bit f);
    bit raw, waw, str, st, wbv;
    bit [4:0] wbd;
    bit [N-1:0] sv;
    int k, dummy;
    reset = rs;
    issue_valid = v;
    issue_is_mul = m;
    issue_wr = w;
    issue_dst = d;
    issue_src1 = s1;
    issue_src2 = s2;
    flush = fl;
    @(negedge clk);
    if (rs) clear_model();
    while (m_t.size() > 0 && now - m_t[0] > N) begin
      dummy = m_t.pop_front();
      wbd = m_d.pop_front();
      wbv = m_w.pop_front();
    end
    raw = 0;
    waw = 0;
    wbv = 0;
    wbd = '0;
    sv = '0;
    foreach (m_t[i]) begin
      k = now - m_t[i];
      sv[k-1] = 1'b1;
      if ((s1 != 0 && s1 == m_d[i]) || (s2 != 0 && s2 == m_d[i])) raw = 1;
      if (w && d != 0 && d == m_d[i]) waw = 1;
      if (k == N && m_w[i]) begin
        wbv = 1;
        wbd = m_d[i];
      end
    end
    str = v && w && !m && resv[now + L];
    st = v && (raw || waw || str);
    f = v && !st && !fl;
    chk("issue_stall", {31'b0, issue_stall}, {31'b0, st});
    chk("issue_fire", {31'b0, issue_fire}, {31'b0, f});
    chk("stage_valid", 32'(stage_valid), 32'(sv));
    chk("mul_wb_valid", {31'b0, mul_wb_valid}, {31'b0, wbv});
    if (wbv) chk("mul_wb_dst", 32'(mul_wb_dst), 32'(wbd));
    chk("mul_inflight", 32'(mul_inflight), 32'(m_t.size()));
    if (fl || rs) clear_model();
    else if (f) begin
      if (m) begin
        m_t.push_back(now);
        m_d.push_back(d);
        m_w.push_back(w);
      end
      if (w) resv[now + (m ? N : L)] = 1'b1;
    end
    now++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bit f;
    repeat (n) step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, f);
  endtask
  task automatic issue(input bit m, input bit w, input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2);
    bit f;
    int n;
    n = 0;
    do begin
      step(1, m, w, d, s1, s2, 0, 0, f);
      n++;
    end while (!f && n < 20);
    chk("issue_accepted", {31'b0, issue_fire | f}, 32'd1);
  endtask
  initial begin
    bit f, rs, v, m, w, fl;
    bit [4:0] d, s1, s2;
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, f);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, f);
    idle(2);
    issue(1, 1, 5'd4, 5'd0, 5'd0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, f);
    idle(8);
    issue(1, 1, 5'd3, 5'd0, 5'd0);
    issue(0, 1, 5'd9, 5'd3, 5'd0);
    idle(6);
    issue(1, 1, 5'd5, 5'd0, 5'd0);
    idle(1);
    issue(0, 1, 5'd6, 5'd0, 5'd0);
    idle(7);
    for (int i = 1; i <= 5; i++) issue(1, 1, 5'(i), 5'd0, 5'd0);
    idle(8);
    issue(1, 1, 5'd7, 5'd0, 5'd0);
    idle(1);
    step(1, 1, 1, 5'd8, 5'd0, 5'd0, 1, 0, f);
    idle(7);
    issue(1, 1, 5'd0, 5'd0, 5'd0);
    issue(0, 1, 5'd0, 5'd0, 5'd0);
    issue(0, 1, 5'd0, 5'd0, 5'd0);
    idle(7);
    issue(1, 0, 5'd2, 5'd0, 5'd0);
    issue(0, 1, 5'd2, 5'd0, 5'd0);
    idle(7);
    for (int i = 0; i < 900; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      v = !rs && ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 4) != 0);
      d = 5'($urandom_range(0, 7));
      s1 = 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 29) == 0);
      step(v, m, w, d, s1, s2, fl, rs, f);
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
